load_writeback_unit: RTL

Writeback stage feeding the register unit's write port (`reg_write_en`, `rd`, `rd_value`). It accepts one execute-stage result per handshake. Non-load results are forwarded to the register unit. Loads run a request/acknowledge read on the data-memory port, then the returned word is lane-selected and sign- or zero-extended before writeback. A timeout aborts a load whose memory read never completes.

---
 rtl/load_writeback_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/load_writeback_unit.sv
// rtl/load_writeback_unit.sv - writeback stage: forwards ALU results, runs and extends memory loads.
// Optional feature macro: WB_MISALIGN_TRAP_EN (misaligned LH/LHU/LW raise load_fault instead of reading).
module load_writeback_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_load,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic        in_wb_en,
    input  logic [31:0] in_alu_result,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        reg_write_en,
    output logic [4:0]  rd,
    output logic [31:0] rd_value,
    output logic        load_fault
);

    typedef enum logic {
        ST_IDLE,
        ST_MEM_WAIT
    } state_t;

    localparam logic [31:0] LP_TIMEOUT = 32'(TIMEOUT_CYCLES);

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [4:0]  r_rd;
    logic        r_wb_en;

    state_t      w_state_nxt;
    logic [31:0] w_cnt_nxt;
    logic        w_capture;
    logic        w_req_nxt;
    logic [31:0] w_addr_nxt;
    logic        w_we_nxt;
    logic [4:0]  w_rd_nxt;
    logic [31:0] w_val_nxt;
    logic        w_fault_nxt;
    logic        w_accept;
    logic        w_misalign;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;

    assign in_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept = in_valid && in_ready;

`ifdef WB_MISALIGN_TRAP_EN
    assign w_misalign = ((in_funct3[1:0] == 2'b01) && in_alu_result[0]) ||
                        ((in_funct3 == 3'b010) && (in_alu_result[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Lane select uses the captured address offset; undefined funct3 falls through to a full word.
    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_off)
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            2'd3:    w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_val = {24'd0, w_byte};
            3'b101:  w_load_val = {16'd0, w_half};
            default: w_load_val = mem_rdata;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_req_nxt   = mem_req;
        w_addr_nxt  = mem_addr;
        w_we_nxt    = 1'b0;
        w_rd_nxt    = rd;
        w_val_nxt   = rd_value;
        w_fault_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!in_is_load) begin
                        w_we_nxt = in_wb_en && (in_rd != 5'd0);
                        if (w_we_nxt) begin
                            w_rd_nxt  = in_rd;
                            w_val_nxt = in_alu_result;
                        end
                    end else if (w_misalign) begin
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_capture   = 1'b1;
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = {in_alu_result[31:2], 2'b00};
                        w_cnt_nxt   = 32'd0;
                        w_state_nxt = ST_MEM_WAIT;
                    end
                end
            end
            ST_MEM_WAIT: begin
                // An ack in the limit cycle takes priority over the timeout.
                if (mem_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                    w_we_nxt    = r_wb_en && (r_rd != 5'd0);
                    if (w_we_nxt) begin
                        w_rd_nxt  = r_rd;
                        w_val_nxt = w_load_val;
                    end
                end else if ((LP_TIMEOUT != 32'd0) && ((r_cnt + 32'd1) == LP_TIMEOUT)) begin
                    w_req_nxt   = 1'b0;
                    w_fault_nxt = 1'b1;
                    w_cnt_nxt   = 32'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 32'd0;
            r_funct3     <= 3'd0;
            r_off        <= 2'd0;
            r_rd         <= 5'd0;
            r_wb_en      <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= 32'd0;
            reg_write_en <= 1'b0;
            rd           <= 5'd0;
            rd_value     <= 32'd0;
            load_fault   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            mem_req      <= w_req_nxt;
            mem_addr     <= w_addr_nxt;
            reg_write_en <= w_we_nxt;
            rd           <= w_rd_nxt;
            rd_value     <= w_val_nxt;
            load_fault   <= w_fault_nxt;
            if (w_capture) begin
                r_funct3 <= in_funct3;
                r_off    <= in_alu_result[1:0];
                r_rd     <= in_rd;
                r_wb_en  <= in_wb_en;
            end
        end
    end

endmodule
